// File: rtl/text_ram_pkg.sv
// Shared constants and FSM encoding for the text RAM write engine.
// Control codes and the printable range are fixed ASCII values; the state type
// gains StRowClr when TEXT_WRITER_ROW_CLEAR_EN is defined.
package text_ram_pkg;

  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

`ifdef TEXT_WRITER_ROW_CLEAR_EN
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPut    = 2'd1,
    StClear  = 2'd2,
    StRowClr = 2'd3
  } wr_state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPut   = 2'd1,
    StClear = 2'd2
  } wr_state_e;
`endif

endpackage

// File: rtl/text_ram_writer_if.sv
// Character stream into the text RAM writer.
//   char_valid  source -> engine  char_data holds a character
//   char_data   source -> engine  character or control code
//   char_ready  engine -> source  engine can accept a character this cycle
//   clear_req   source -> engine  single-cycle clear-screen request
// master = character source (CPU/UART), slave = text_ram_writer.
interface text_ram_writer_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  char_valid;
  logic [DATA_WIDTH-1:0] char_data;
  logic                  char_ready;
  logic                  clear_req;

  modport master (
    output char_valid,
    output char_data,
    output clear_req,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_data,
    input  clear_req,
    output char_ready
  );

endinterface

// File: rtl/text_cursor.sv
// Cursor counters for the text RAM writer: row, column and row_base (= row*COLS),
// the latter kept as a running sum so no multiplier is needed.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   inc                  advance one column, wrapping to the next row at COLS-1
//   newline              column 0, next row
//   cr                   column 0, same row
//   back                 column - 1 (caller guarantees col > 0)
//   home                 cursor to (0,0); highest priority
//   row, col, row_base   current cursor state
//   row_adv              combinational: this cycle's command moves to a new row
// Rows wrap from ROWS-1 to 0 (no scrolling).
module text_cursor #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    newline,
  input  logic                    cr,
  input  logic                    back,
  input  logic                    home,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic [ADDR_WIDTH-1:0]   row_base,
  output logic                    row_adv
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  always_comb begin
    row_adv = newline || (inc && (col == CW'(COLS - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst || home) begin
      row      <= '0;
      col      <= '0;
      row_base <= '0;
    end else if (row_adv) begin
      col <= '0;
      if (row == RW'(ROWS - 1)) begin
        row      <= '0;
        row_base <= '0;
      end else begin
        row      <= row + RW'(1);
        row_base <= row_base + ADDR_WIDTH'(COLS);
      end
    end else if (inc) begin
      col <= col + CW'(1);
    end else if (cr) begin
      col <= '0;
    end else if (back) begin
      col <= col - CW'(1);
    end
  end

endmodule

// File: rtl/text_ram_writer.sv
// Write-side engine for the dual-port text RAM (VGA scanner owns the read port).
// Accepts characters, tracks a cursor and drives the RAM write port; also runs a
// full-screen clear.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   chars (slave)           char_valid/char_data/char_ready handshake + clear_req
//   busy                    high while the FSM is not idle
//   we, write_addr, data    registered RAM write port
//   cursor_row, cursor_col  current cursor position
// Option TEXT_WRITER_ROW_CLEAR_EN: every row advance (LF or wrap) fills the new
// row with FILL_CHAR before accepting the next character.
module text_ram_writer
  import text_ram_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          ADDR_WIDTH = 12,
  parameter int unsigned          COLS       = 80,
  parameter int unsigned          ROWS       = 30,
  parameter logic [DATA_WIDTH-1:0] FILL_CHAR = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst,
  text_ram_writer_if.slave        chars,
  output logic                    busy,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [$clog2(COLS)-1:0] cursor_col
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(COLS * ROWS - 1);

  wr_state_e             state_q;
  logic                  accept, clear_go;
  logic                  is_print, is_lf, is_cr, is_bs, col_nz;
  logic                  row_adv;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] cur_addr;

  always_comb begin
    clear_go = (state_q == StIdle) && chars.clear_req;
    // clear_req wins: a same-cycle character is dropped, not consumed.
    accept   = (state_q == StIdle) && chars.char_valid && !chars.clear_req;
    is_print = (chars.char_data >= DATA_WIDTH'(PRINT_MIN)) &&
               (chars.char_data <= DATA_WIDTH'(PRINT_MAX));
    is_lf    = chars.char_data == DATA_WIDTH'(CH_LF);
    is_cr    = chars.char_data == DATA_WIDTH'(CH_CR);
    is_bs    = chars.char_data == DATA_WIDTH'(CH_BS);
    col_nz   = cursor_col != '0;
    cur_addr = row_base + ADDR_WIDTH'(cursor_col);
    chars.char_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
  end

  text_cursor #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept && is_print),
    .newline  (accept && is_lf),
    .cr       (accept && is_cr),
    .back     (accept && is_bs && col_nz),
    .home     (clear_go),
    .row      (cursor_row),
    .col      (cursor_col),
    .row_base (row_base),
    .row_adv  (row_adv)
  );

`ifdef TEXT_WRITER_ROW_CLEAR_EN
  localparam int unsigned FW = $clog2(COLS + 1);
  logic [FW-1:0] fill_idx_q;
`else
  logic unused_row_adv;
  assign unused_row_adv = row_adv;
`endif

  // Write-port outputs are registered at the accept edge, alongside the cursor
  // update, so we and the new cursor appear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we         <= 1'b0;
      write_addr <= '0;
      data       <= '0;
`ifdef TEXT_WRITER_ROW_CLEAR_EN
      fill_idx_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          we <= 1'b0;
          if (clear_go) begin
            state_q    <= StClear;
            we         <= 1'b1;
            write_addr <= '0;
            data       <= FILL_CHAR;
          end else if (accept) begin
`ifdef TEXT_WRITER_ROW_CLEAR_EN
            state_q    <= row_adv ? StRowClr : StPut;
            fill_idx_q <= '0;
`else
            state_q    <= StPut;
`endif
            if (is_print) begin
              we         <= 1'b1;
              write_addr <= cur_addr;
              data       <= chars.char_data;
            end else if (is_bs && col_nz) begin
              we         <= 1'b1;
              write_addr <= cur_addr - ADDR_WIDTH'(1);
              data       <= FILL_CHAR;
            end
          end
        end
        StPut: begin
          we      <= 1'b0;
          state_q <= StIdle;
        end
        StClear: begin
          // write_addr doubles as the clear counter.
          if (write_addr == LastAddr) begin
            we      <= 1'b0;
            state_q <= StIdle;
          end else begin
            we         <= 1'b1;
            write_addr <= write_addr + ADDR_WIDTH'(1);
            data       <= FILL_CHAR;
          end
        end
`ifdef TEXT_WRITER_ROW_CLEAR_EN
        StRowClr: begin
          // row_base already points at the new row here.
          if (fill_idx_q == FW'(COLS)) begin
            we      <= 1'b0;
            state_q <= StIdle;
          end else begin
            we         <= 1'b1;
            write_addr <= row_base + ADDR_WIDTH'(fill_idx_q);
            data       <= FILL_CHAR;
            fill_idx_q <= fill_idx_q + FW'(1);
          end
        end
`endif
        default: begin
          we      <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_ram_writer.sv
module tb_text_ram_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int NCELL = COLS * ROWS;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [7:0]  ch;
    bit          exp_we;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
    int          exp_row;
    int          exp_col;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy, we;
  logic [11:0] write_addr;
  logic [7:0]  data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  always #5 clk = ~clk;

  text_ram_writer_if #(.DATA_WIDTH(8)) chars ();

  text_ram_writer dut (
    .clk        (clk),
    .rst        (rst),
    .chars      (chars),
    .busy       (busy),
    .we         (we),
    .write_addr (write_addr),
    .data       (data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  int  total = 0;
  int  bad = 0;
  wr_t wq[$];
  wr_t eq[$];
  int  mr = 0;
  int  mc = 0;

  always @(negedge clk) if (!rst && we) wq.push_back({write_addr, data});

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: screen as row/col with plain arithmetic addresses.
  task automatic model_advance_row();
    mc = 0;
    mr = (mr + 1) % ROWS;
`ifdef TEXT_WRITER_ROW_CLEAR_EN
    for (int k = 0; k < COLS; k++) eq.push_back({12'(mr * COLS + k), 8'h20});
`endif
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      eq.push_back({12'(mr * COLS + mc), c});
      if (mc == COLS - 1) model_advance_row();
      else mc++;
    end else if (c == 8'h0A) begin
      model_advance_row();
    end else if (c == 8'h0D) begin
      mc = 0;
    end else if (c == 8'h08 && mc > 0) begin
      mc--;
      eq.push_back({12'(mr * COLS + mc), 8'h20});
    end
  endtask

  task automatic model_clear();
    mr = 0;
    mc = 0;
    for (int a = 0; a < NCELL; a++) eq.push_back({12'(a), 8'h20});
  endtask

  task automatic run_op(input logic [7:0] c, input bit clr, output int busy_cycles);
    int n;
    wq.delete();
    @(negedge clk);
    chars.char_valid = 1'b1;
    chars.char_data  = c;
    chars.clear_req  = clr;
    @(posedge clk);
    #1;
    chars.char_valid = 1'b0;
    chars.clear_req  = 1'b0;
    busy_cycles = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_cycles++;
    end while (busy && n < 6000);
    check("idle after op", {31'd0, busy}, 0);
  endtask

  task automatic compare_writes(input string name);
    int first;
    check({name, " write count"}, wq.size(), eq.size());
    if (wq.size() == eq.size()) begin
      first = -1;
      for (int i = 0; i < wq.size(); i++) begin
        if (wq[i] !== eq[i]) begin
          first = i;
          break;
        end
      end
      total++;
      if (first >= 0) begin
        bad++;
        $display("FAIL %s write[%0d]: got addr %0d data %0h expected addr %0d data %0h",
                 name, first, wq[first].addr, wq[first].d, eq[first].addr, eq[first].d);
      end
    end
    check({name, " row"}, cursor_row, mr);
    check({name, " col"}, cursor_col, mc);
  endtask

  task automatic do_char(input logic [7:0] c, input string name);
    int b;
    eq.delete();
    model_char(c);
    run_op(c, 1'b0, b);
    compare_writes(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    mr = 0;
    mc = 0;
    wq.delete();
  endtask

  vec_t tbl[11];

  initial begin
    int b, n;
    logic [7:0] c;

    chars.char_valid = 1'b0;
    chars.char_data  = 8'h00;
    chars.clear_req  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset we", {31'd0, we}, 0);
    check("reset addr", write_addr, 0);
    check("reset data", data, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset ready", {31'd0, chars.char_ready}, 1);
    check("reset row", cursor_row, 0);
    check("reset col", cursor_col, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table: single-write characters and no-op codes from (0,0)
    tbl[0]  = '{8'h41, 1'b1, 12'd0, 8'h41, 0, 1};
    tbl[1]  = '{8'h42, 1'b1, 12'd1, 8'h42, 0, 2};
    tbl[2]  = '{8'h08, 1'b1, 12'd1, 8'h20, 0, 1};
    tbl[3]  = '{8'h0D, 1'b0, 12'd0, 8'h00, 0, 0};
    tbl[4]  = '{8'h08, 1'b0, 12'd0, 8'h00, 0, 0};
    tbl[5]  = '{8'h01, 1'b0, 12'd0, 8'h00, 0, 0};
    tbl[6]  = '{8'h7E, 1'b1, 12'd0, 8'h7E, 0, 1};
    tbl[7]  = '{8'h7F, 1'b0, 12'd0, 8'h00, 0, 1};
    tbl[8]  = '{8'h1F, 1'b0, 12'd0, 8'h00, 0, 1};
    tbl[9]  = '{8'h20, 1'b1, 12'd1, 8'h20, 0, 2};
    tbl[10] = '{8'h43, 1'b1, 12'd2, 8'h43, 0, 3};
    for (int i = 0; i < 11; i++) begin
      eq.delete();
      model_char(tbl[i].ch);
      run_op(tbl[i].ch, 1'b0, b);
      check($sformatf("tbl%0d writes", i), wq.size(), tbl[i].exp_we ? 1 : 0);
      if (tbl[i].exp_we && wq.size() == 1) begin
        check($sformatf("tbl%0d addr", i), wq[0].addr, tbl[i].exp_addr);
        check($sformatf("tbl%0d data", i), wq[0].d, tbl[i].exp_data);
      end
      check($sformatf("tbl%0d row", i), cursor_row, tbl[i].exp_row);
      check($sformatf("tbl%0d col", i), cursor_col, tbl[i].exp_col);
    end

    // 80 'x' across row 0, then 'y' lands at 80
    do_reset();
    for (int i = 0; i < COLS; i++) do_char(8'h78, "row0 x");
    check("row0 last addr", wq.size() > 0 ? wq[0].addr : 12'hFFF, 79);
    check("row0 end row", cursor_row, 1);
    check("row0 end col", cursor_col, 0);
    do_char(8'h79, "y at 80");
    check("y addr", wq.size() > 0 ? wq[0].addr : 12'hFFF, 80);

    // Walk to (29,79) and wrap the screen
    do_char(8'h0D, "cr");
    for (int i = 0; i < 28; i++) do_char(8'h0A, "lf");
    for (int i = 0; i < COLS - 1; i++) do_char(8'h61 + 8'(i % 26), "row29");
    check("at 29 row", cursor_row, 29);
    check("at 29 col", cursor_col, 79);
    do_char(8'h7A, "wrap z");
    check("wrap addr", wq.size() > 0 ? wq[0].addr : 12'hFFF, 2399);
    check("wrap data", wq.size() > 0 ? wq[0].d : 8'h00, 8'h7A);

    // Clear with a same-cycle char; a second clear_req mid-clear is ignored
    do_char(8'h6B, "pre-clear");
    eq.delete();
    model_clear();
    wq.delete();
    @(negedge clk);
    chars.char_valid = 1'b1;
    chars.char_data  = 8'h51;
    chars.clear_req  = 1'b1;
    check("clear ready", {31'd0, chars.char_ready}, 1);
    @(posedge clk);
    #1;
    chars.char_valid = 1'b0;
    chars.clear_req  = 1'b0;
    b = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) b++;
      chars.clear_req = (n == 50);
    end while (busy && n < 6000);
    chars.clear_req = 1'b0;
    check("clear busy cycles", b, NCELL);
    compare_writes("clear");
    repeat (3) @(negedge clk);
    check("clear no re-trigger", {31'd0, busy}, 0);

    // Reset in the middle of a clear
    @(negedge clk);
    chars.clear_req = 1'b1;
    @(posedge clk);
    #1;
    chars.clear_req = 1'b0;
    repeat (100) @(negedge clk);
    check("mid-clear busy", {31'd0, busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort we", {31'd0, we}, 0);
    check("abort busy", {31'd0, busy}, 0);
    check("abort ready", {31'd0, chars.char_ready}, 1);
    check("abort row", cursor_row, 0);
    @(negedge clk);
    rst = 1'b0;
    mr = 0;
    mc = 0;
    wq.delete();

`ifdef TEXT_WRITER_ROW_CLEAR_EN
    do_char(8'h0A, "lf rowclr");
    check("rowclr count", wq.size(), 80);
    check("rowclr first", wq.size() > 0 ? wq[0].addr : 12'hFFF, 80);
    check("rowclr last", wq.size() > 0 ? wq[wq.size()-1].addr : 12'hFFF, 159);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60)      c = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 70) c = 8'h0A;
      else if (r < 75) c = 8'h0D;
      else if (r < 88) c = 8'h08;
      else             c = 8'($urandom_range(0, 255));
      if (r >= 98) begin
        eq.delete();
        model_clear();
        run_op(c, 1'b1, b);
        check("rand clear busy", b, NCELL);
        compare_writes("rand clear");
      end else begin
        do_char(c, $sformatf("rand%0d ch %0h", i, c));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
